// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle registered push/error strobes a cycle after the stop-bit sample.
// No backpressure: FULL at the stop-bit sample drops the byte and pulses OVERRUN instead of FIFO_E.
module uart_rx #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX,
   input  logic                  FULL,
   output logic                  FIFO_E,
   output logic                  FIFO_R_WR,
   output logic [DATA_WIDTH-1:0] FIFO_DATA,
   output logic                  FRAME_ERR,
   output logic                  OVERRUN,
   output logic                  BUSY
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int IDX_W        = $clog2(DATA_WIDTH) + 1;

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t                  state_q, state_d;
   logic                    rx_meta_q, rx_meta_d;
   logic                    rx_s_q, rx_s_d;
   logic [CNT_W-1:0]        clk_cnt_q, clk_cnt_d;
   logic [IDX_W-1:0]        bit_idx_q, bit_idx_d;
   logic [DATA_WIDTH-1:0]   shift_q, shift_d;
   logic [DATA_WIDTH-1:0]   fifo_data_q, fifo_data_d;
   logic                    fifo_e_q, fifo_e_d;
   logic                    frame_err_q, frame_err_d;
   logic                    overrun_q, overrun_d;

   always_comb begin
      rx_meta_d   = RX;
      rx_s_d      = rx_meta_q;
      state_d     = state_q;
      clk_cnt_d   = clk_cnt_q + CNT_W'(1);
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      fifo_data_d = fifo_data_q;
      fifo_e_d    = 1'b0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            clk_cnt_d = '0;
            if (!rx_s_q) state_d = S_START;
         end
         S_START: begin
            // Half-bit check both rejects glitches and aligns later samples to mid-bit.
            if (clk_cnt_q == HALF_LAST) begin
               clk_cnt_d = '0;
               bit_idx_d = '0;
               state_d   = rx_s_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (clk_cnt_q == BIT_LAST) begin
               clk_cnt_d = '0;
               shift_d   = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
               bit_idx_d = bit_idx_q + IDX_W'(1);
               if (bit_idx_q == IDX_LAST) state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (clk_cnt_q == BIT_LAST) begin
               clk_cnt_d = '0;
               if (!rx_s_q) begin
                  frame_err_d = 1'b1;
                  state_d     = S_BREAK;
               end else begin
                  state_d = S_IDLE;
                  if (FULL) begin
                     overrun_d = 1'b1;
                  end else begin
                     fifo_data_d = shift_q;
                     fifo_e_d    = 1'b1;
                  end
               end
            end
         end
         S_BREAK: begin
            // Wait out a held-low line so it yields a single framing error.
            clk_cnt_d = '0;
            if (rx_s_q) state_d = S_IDLE;
         end
         default: begin
            clk_cnt_d = '0;
            state_d   = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= S_IDLE;
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         clk_cnt_q   <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         fifo_data_q <= '0;
         fifo_e_q    <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rx_meta_q   <= rx_meta_d;
         rx_s_q      <= rx_s_d;
         clk_cnt_q   <= clk_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         fifo_data_q <= fifo_data_d;
         fifo_e_q    <= fifo_e_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign FIFO_E    = fifo_e_q;
   assign FIFO_R_WR = 1'b1;
   assign FIFO_DATA = fifo_data_q;
   assign FRAME_ERR = frame_err_q;
   assign OVERRUN   = overrun_q;
   assign BUSY      = (state_q != S_IDLE);

endmodule
